uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter TO_W, default 16: width of the timeout counter and of timeout_cycles.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-005 req  input  NREQ  level request per requester; requester i is req[i].
REQ-006 req_data  input  NREQ*8  byte per requester; requester i at bits [8i+7:8i].
REQ-007 timeout_cycles  input  TO_W  max WAIT cycles before abort; 0 disables timeout.
REQ-008 tx_done  input  1  one-cycle completion pulse from transmitter, clk domain.
REQ-009 err_clr  input  1  clears err when high.
REQ-010 tx_start  output  1  one-cycle start pulse to transmitter.
REQ-011 tx_data  output  8  byte for transmitter, stable from START through DONE.
REQ-012 gnt  output  NREQ  one-hot grant, high from START through DONE inclusive.
REQ-013 ack  output  NREQ  one-cycle completion pulse to the served requester.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  sticky timeout flag.
REQ-016 err_id  output  $clog2(NREQ)  index of requester whose transfer timed out most recently.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, DONE; all outputs registered or decoded from registered state only.
REQ-018 IDLE: if any req bit high, select winner and go to START next cycle; else stay IDLE.
REQ-019 Arbitration SHALL be round-robin: search begins at index (last_served+1) mod NREQ, wraps, first asserted req wins.
REQ-020 On IDLE->START edge, gnt[winner]=1 and tx_data=req_data[winner] SHALL be latched; later req_data changes ignored.
REQ-021 START lasts exactly one cycle with tx_start=1; next state WAIT; latency req-high-in-IDLE to tx_start = 1 cycle.
REQ-022 WAIT: counter starts at 0, increments each WAIT cycle; tx_done=1 -> DONE (success).
REQ-023 WAIT: timeout_cycles!=0 and counter==timeout_cycles-1 without tx_done -> DONE (abort); err=1, err_id=winner.
REQ-024 tx_done and timeout in same cycle: success wins, err unchanged.
REQ-025 DONE lasts one cycle: ack[winner]=1 (success and abort alike), last_served=winner; next cycle gnt=0, state IDLE.
REQ-026 tx_done outside WAIT SHALL be ignored.
REQ-027 req[winner] deasserting after grant SHALL NOT cancel the transfer; ack still pulses.
REQ-028 Back-to-back: requester still high after its ack is served again only after every other asserted requester.
REQ-029 err_clr=1 clears err next edge; if abort occurs same cycle, err set wins; err_id holds value.
REQ-030 timeout_cycles sampled each WAIT cycle; changing it mid-transfer takes effect immediately.

Reset
REQ-031 rst=0: state=IDLE, tx_start=0, tx_data=0, gnt=0, ack=0, busy=0, err=0, err_id=0, counter=0, last_served=NREQ-1 (requester 0 has first priority).
REQ-032 rst=0 mid-transfer SHALL abort with no ack pulse; after release, arbitration restarts from requester 0.

Verification
REQ-033 req=4'b0001, req_data[7:0]=8'hA5, tx_done 5 cycles after tx_start -> tx_start 1 cycle after req, tx_data=8'hA5, gnt=0001 for 7 cycles, ack[0] single pulse, err=0.
REQ-034 req=4'b1111 held, tx_done 3 cycles after each tx_start -> grant order 0,1,2,3,0, each ack once per grant.
REQ-035 timeout_cycles=10, req=4'b0100, no tx_done -> DONE after 10 WAIT cycles, err=1, err_id=2, ack[2] pulses; err_clr pulse -> err=0.
REQ-036 timeout_cycles=4, tx_done on 4th WAIT cycle -> success, err stays 0; timeout_cycles=0 with tx_done after 1000 cycles -> no abort.
REQ-037 rst=0 asserted asynchronously during WAIT of requester 1 -> all outputs 0 immediately, no ack; after release with req=4'b0011 -> requester 0 granted first.
REQ-038 tx_done pulses in IDLE and START -> no state change, no ack.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Latches winner and byte, times out stalled transfers, flags sticky error.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int TO_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8-1:0]        req_data,
  input  logic [TO_W-1:0]          timeout_cycles,
  input  logic                     tx_done,
  input  logic                     err_clr,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(NREQ)-1:0]  err_id
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      data_q, data_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [IW-1:0]   eid_q, eid_d;
  logic [IW-1:0]   sel;
  logic            found;
  logic            timeout;
  int unsigned     idx;

  // search starts just after the last served requester and wraps
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign timeout = (timeout_cycles != '0) &&
                   (cnt_q == timeout_cycles - TO_W'(1));

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    eid_d   = eid_q;
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = START;
          win_d   = sel;
          data_d  = req_data[8*sel +: 8];
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (tx_done) begin
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          eid_d   = win_q;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      eid_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      eid_q   <= eid_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign tx_start = (state_q == START);
  assign tx_data  = data_q;
  assign gnt      = busy ? (NREQ'(1) << win_q) : '0;
  assign ack      = (state_q == DONE) ? (NREQ'(1) << win_q) : '0;
  assign err      = err_q;
  assign err_id   = eid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed transfers, timeouts,
// round-robin order and asynchronous reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [15:0] timeout_cycles = '0;
  logic        tx_done = 1'b0;
  logic        err_clr = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic        err;
  logic [1:0]  err_id;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];

  uart_tx_arbiter #(.NREQ(4), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .timeout_cycles(timeout_cycles), .tx_done(tx_done),
    .err_clr(err_clr), .tx_start(tx_start), .tx_data(tx_data),
    .gnt(gnt), .ack(ack), .busy(busy), .err(err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    tick();
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(tx_start), 32'd1);
  endtask

  task automatic done_after(int n);
    repeat (n) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic push(int id, logic [7:0] d, logic e);
    exp_t x;
    x.id = id;
    x.data = d;
    x.err = e;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst && ack != '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 32'(ack), 32'd0);
        end else begin
          x = sb.pop_front();
          chk("sb_ack", 32'(ack), 32'(4'b0001 << x.id));
          chk("sb_gnt", 32'(gnt), 32'(4'b0001 << x.id));
          chk("sb_data", 32'(tx_data), 32'(x.data));
          chk("sb_err", 32'(err), 32'(x.err));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int g;
    #3;
    chk("rst_outputs",
        32'({tx_start, busy, err, err_id, gnt, ack, tx_data}), 32'd0);
    #19 rst = 1'b1;

    // single transfer, byte latched at grant
    req = 4'b0001;
    req_data = 32'h000000A5;
    push(0, 8'hA5, 1'b0);
    tick();
    chk("t1_latency", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    req_data[7:0] = 8'h3C;
    g = (gnt == 4'b0001) ? 1 : 0;
    repeat (5) begin
      tick();
      if (gnt == 4'b0001) g++;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    req = '0;
    if (gnt == 4'b0001) g++;
    chk("t1_ack", 32'(ack), 32'd1);
    tick();
    chk("t1_gnt_cycles", 32'(g), 32'd7);
    chk("t1_ack_single", 32'(ack), 32'd0);
    chk("t1_gnt_off", 32'(gnt), 32'd0);

    // fresh reset, all requesters held
    #3 rst = 1'b0;
    #3 rst = 1'b1;
    req = 4'b1111;
    req_data = 32'h44332211;
    push(0, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(2, 8'h33, 1'b0);
    push(3, 8'h44, 1'b0);
    push(0, 8'h11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_start();
      done_after(3);
    end
    req = '0;
    tick();

    // timeout abort on requester 2, req dropped after grant
    timeout_cycles = 16'd10;
    req = 4'b0100;
    req_data[23:16] = 8'h5A;
    push(2, 8'h5A, 1'b1);
    wait_start();
    req = '0;
    repeat (10) tick();
    chk("t3_no_early_ack", 32'(ack), 32'd0);
    tick();
    chk("t3_ack", 32'(ack), 32'b0100);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_err_id", 32'(err_id), 32'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(err), 32'd0);
    chk("t3_err_id_hold", 32'(err_id), 32'd2);
    chk("t3_idle", 32'(busy), 32'd0);

    // done coincides with timeout: success wins
    timeout_cycles = 16'd4;
    req = 4'b0010;
    req_data[15:8] = 8'h77;
    push(1, 8'h77, 1'b0);
    wait_start();
    req = '0;
    done_after(4);
    chk("t4_ack", 32'(ack), 32'b0010);
    chk("t4_err", 32'(err), 32'd0);
    tick();

    // timeout disabled, long wait
    timeout_cycles = 16'd0;
    req = 4'b0001;
    req_data[7:0] = 8'h99;
    push(0, 8'h99, 1'b0);
    wait_start();
    req = '0;
    done_after(1000);
    chk("t4b_ack", 32'(ack), 32'b0001);
    chk("t4b_err", 32'(err), 32'd0);
    tick();

    // stray done pulses in IDLE and START
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_ack", 32'(ack), 32'd0);
    req = 4'b1000;
    req_data[31:24] = 8'hC3;
    push(3, 8'hC3, 1'b0);
    tick();
    chk("t5_start", 32'(tx_start), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_wait_busy", 32'(busy), 32'd1);
    chk("t5_wait_ack", 32'(ack), 32'd0);
    chk("t5_wait_nostart", 32'(tx_start), 32'd0);
    req = '0;
    done_after(2);
    chk("t5_ack", 32'(ack), 32'b1000);
    tick();

    // async reset during WAIT of requester 1
    req = 4'b0010;
    req_data[15:8] = 8'h5E;
    wait_start();
    tick();
    tick();
    #3 rst = 1'b0;
    #1;
    chk("t6_async_rst",
        32'({tx_start, busy, err, err_id, gnt, ack, tx_data}), 32'd0);
    req = 4'b0011;
    req_data[7:0] = 8'hD0;
    req_data[15:8] = 8'hD1;
    push(0, 8'hD0, 1'b0);
    push(1, 8'hD1, 1'b0);
    #10 rst = 1'b1;
    wait_start();
    chk("t6_first_gnt", 32'(gnt), 32'b0001);
    done_after(1);
    wait_start();
    req = '0;
    done_after(1);
    chk("t6_second_ack", 32'(ack), 32'b0010);
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
